serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits, legal range 1..32.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have ports a and b, input, WIDTH bits each, operands captured on start acceptance.
REQ-006 SHALL have port cin, input, 1 bit, carry-in captured on start acceptance.
REQ-007 SHALL have port busy, output, 1 bit, high in RUN and DONE states.
REQ-008 SHALL have port done, output, 1 bit, single-cycle pulse when the result is valid.
REQ-009 SHALL have port sum, output, WIDTH bits, registered result.
REQ-010 SHALL have port cout, output, 1 bit, registered final carry-out.
REQ-011 SHALL have port overflow, output, 1 bit, registered signed overflow flag.

Function
REQ-012 SHALL sequence exactly one 1-bit full-adder slice (sum = x^y^c, carry = majority(x,y,c)) over WIDTH cycles, LSB first.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the WIDTH-th bit; DONE->IDLE unconditionally next cycle.
REQ-014 SHALL, on acceptance, load a and b into shift registers, load cin into the carry flop, clear the bit counter and clear sum.
REQ-015 SHALL, each RUN cycle, add operand bit 0s with the carry flop, shift both operands right, shift the result bit into sum MSB-first-in so sum is LSB-aligned after WIDTH cycles, and update the carry flop.
REQ-016 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits; RUN terminates when counter reaches WIDTH-1 on the active cycle.
REQ-017 SHALL assert done for exactly one cycle in DONE; start accepted in cycle T gives done high in cycle T+WIDTH+1.
REQ-018 SHALL set cout to the final carry and overflow to carry-into-MSB XOR carry-out-of-MSB, both updated on the last RUN cycle.
REQ-019 SHALL hold sum, cout, overflow stable from DONE until the next accepted start.
REQ-020 SHALL ignore start while busy=1, including start held high continuously; held start restarts only once back in IDLE.
REQ-021 SHALL, for WIDTH=1, spend exactly one RUN cycle.
REQ-022 SHALL not sample a, b, cin outside the acceptance cycle; changes during RUN have no effect.

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, carry flop=0.
REQ-024 SHALL abort any operation in progress on reset without asserting done, and accept a new start the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL, when macro SERIAL_ADDER_SUB_EN is defined, add input port sub (1 bit) captured on acceptance; sub=1 inverts each b bit into the slice and forces initial carry to 1 (cin ignored), computing a-b; overflow per REQ-018.
REQ-026 SHALL, when SERIAL_ADDER_SUB_EN is undefined, have no sub port and perform addition only; behaviour otherwise identical.

Verification
REQ-027 SHALL cover WIDTH=8, a=0x3C, b=0x05, cin=0 -> done at T+9, sum=0x41, cout=0, overflow=0.
REQ-028 SHALL cover a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; and a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
REQ-029 SHALL cover start pulsed at RUN cycle 3 with different operands -> ignored, result of first operation unchanged, busy stays high until DONE.
REQ-030 SHALL cover rst_n low at RUN cycle 4 -> all outputs 0, no done pulse; then start with a=0x01, b=0x01, cin=1 -> sum=0x03.
REQ-031 SHALL cover start held high for 30 cycles -> back-to-back operations, done every WIDTH+2 cycles.
REQ-032 SHALL cover, with SERIAL_ADDER_SUB_EN defined, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, overflow=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder with IDLE/RUN/DONE control FSM
//
// One full-adder slice processes one operand bit per RUN cycle, LSB first;
// the result is shifted into sum from the MSB end, so it is LSB-aligned
// after WIDTH cycles.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input, which
// selects a - b (b inverted into the slice, initial carry forced to 1).
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin an addition (sampled only in IDLE)
//   a, b     - WIDTH-bit operands, captured on start acceptance
//   cin      - carry-in, captured on start acceptance
//   sub      - (SERIAL_ADDER_SUB_EN only) subtract select, captured on acceptance
//   busy     - high in RUN and DONE
//   done     - one-cycle pulse while the result is valid
//   sum      - registered result
//   cout     - registered final carry-out
//   overflow - registered signed overflow flag
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub_q;
`endif

   logic b_bit;
   logic slice_sum;
   logic slice_carry;
   logic last_bit;

   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_bit = b_q[0] ^ sub_q;
`else
      b_bit = b_q[0];
`endif
      slice_sum   = a_q[0] ^ b_bit ^ carry_q;
      slice_carry = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
      // Written as shift-then-overwrite so WIDTH=1 needs no special case.
      sum_d            = sum_q >> 1;
      sum_d[WIDTH-1]   = slice_sum;
      last_bit         = (cnt_q == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sum_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
                  sub_q   <= sub;
                  carry_q <= sub ? 1'b1 : cin;
`else
                  carry_q <= cin;
`endif
               end
            end
            RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               sum_q   <= sum_d;
               carry_q <= slice_carry;
               if (last_bit) begin
                  cout_q  <= slice_carry;
                  // carry_q is the carry into the MSB on this cycle
                  ovf_q   <= carry_q ^ slice_carry;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
